// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared types and helpers for serial comparator blocks.
// State encoding and a constant-width helper.
package serial_magnitude_comparator_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_magnitude_comparator_slice.sv
// Combinational BPC-bit chained less/equal slice.
// MSB of the slice is resolved first; le freezes once eq drops.
module compare_slice #(
  parameter int BPC = 1
) (
  input  logic [BPC-1:0] a_s,
  input  logic [BPC-1:0] b_s,
  input  logic           le_in,
  input  logic           eq_in,
  output logic           le_out,
  output logic           eq_out
);

  // walk the slice from MSB down, carrying the upper-slice verdict
  always_comb begin
    le_out = le_in;
    eq_out = eq_in;
    for (int i = BPC - 1; i >= 0; i--) begin
      if (eq_out && (a_s[i] != b_s[i])) begin
        eq_out = 1'b0;
        le_out = b_s[i];
      end
    end
  end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator.
// Holds FSM, operand shift registers and the step counter.
module serial_magnitude_comparator
  import serial_magnitude_comparator_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int BPC        = 1,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_less_b,
  output logic             a_equal_b,
  output logic             a_greater_b
);

  localparam int STEPS = WIDTH / BPC;
  localparam int CW    = clog2(STEPS) + 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (WIDTH < 2 || (WIDTH % BPC) != 0) begin : g_bad_cfg
    $error("serial_magnitude_comparator: bad WIDTH/BPC");
  end

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             le;
  logic             eq;
  logic [CW-1:0]    cnt;
  logic             le_n;
  logic             eq_n;
  logic             fin;
  logic [WIDTH-1:0] msb_flip;

  // flipping the sign bit turns two's complement into offset binary
  assign msb_flip = {signed_mode, {(WIDTH-1){1'b0}}};

  compare_slice #(.BPC(BPC)) u_slice (
    .a_s    (sa[WIDTH-1 -: BPC]),
    .b_s    (sb[WIDTH-1 -: BPC]),
    .le_in  (le),
    .eq_in  (eq),
    .le_out (le_n),
    .eq_out (eq_n)
  );

  assign fin = (cnt == LAST) || ((EARLY_EXIT != 0) && !eq_n);

  // control FSM, operand shifting and registered result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      a_less_b    <= 1'b0;
      a_equal_b   <= 1'b0;
      a_greater_b <= 1'b0;
      sa          <= '0;
      sb          <= '0;
      le          <= 1'b0;
      eq          <= 1'b1;
      cnt         <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            sa    <= a ^ msb_flip;
            sb    <= b ^ msb_flip;
            le    <= 1'b0;
            eq    <= 1'b1;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          le  <= le_n;
          eq  <= eq_n;
          sa  <= sa << BPC;
          sb  <= sb << BPC;
          cnt <= cnt + 1'b1;
          if (fin) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b1;
            a_less_b    <= le_n;
            a_equal_b   <= eq_n;
            a_greater_b <= ~le_n & ~eq_n;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench for serial_magnitude_comparator.
// Unit 0: BPC=1 full run; unit 1: BPC=4 early exit.
module tb_serial_magnitude_comparator;

  typedef struct {
    logic [2:0] res;
    int         lat;
    int         e0;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start [2];
  logic        sm [2];
  logic [15:0] a [2];
  logic [15:0] b [2];
  logic        busy [2];
  logic        done [2];
  logic        lt [2];
  logic        eq [2];
  logic        gt [2];

  exp_t exp_q [2][$];
  int   cyc;
  int   n_vec;
  int   n_bad;

  serial_magnitude_comparator #(
    .WIDTH(16), .BPC(1), .EARLY_EXIT(0)
  ) u0 (
    .clk(clk), .rst(rst), .start(start[0]),
    .signed_mode(sm[0]), .a(a[0]), .b(b[0]),
    .busy(busy[0]), .done(done[0]),
    .a_less_b(lt[0]), .a_equal_b(eq[0]),
    .a_greater_b(gt[0])
  );

  serial_magnitude_comparator #(
    .WIDTH(16), .BPC(4), .EARLY_EXIT(1)
  ) u1 (
    .clk(clk), .rst(rst), .start(start[1]),
    .signed_mode(sm[1]), .a(a[1]), .b(b[1]),
    .busy(busy[1]), .done(done[1]),
    .a_less_b(lt[1]), .a_equal_b(eq[1]),
    .a_greater_b(gt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // {lt,eq,gt} from plain integer arithmetic
  function automatic logic [2:0] ref_res(
    input logic [15:0] x, input logic [15:0] y,
    input logic s);
    int ix;
    int iy;
    ix = s ? int'($signed(x)) : int'(x);
    iy = s ? int'($signed(y)) : int'(y);
    if (ix < iy) return 3'b100;
    if (ix == iy) return 3'b010;
    return 3'b001;
  endfunction

  // slices until the first differing bit is seen
  function automatic int ref_lat(
    input logic [15:0] x, input logic [15:0] y,
    input int bpc, input bit ee);
    logic [15:0] d;
    d = x ^ y;
    if (!ee || d == 0) return 16 / bpc;
    for (int i = 15; i >= 0; i--)
      if (d[i]) return (15 - i) / bpc + 1;
    return 16 / bpc;
  endfunction

  task automatic monitor(input int u);
    exp_t e;
    if (rst || !done[u]) return;
    if (exp_q[u].size() == 0) begin
      chk($sformatf("u%0d unexpected done", u), 1, 0);
      return;
    end
    e = exp_q[u].pop_front();
    chk($sformatf("u%0d result", u),
        {29'd0, lt[u], eq[u], gt[u]}, {29'd0, e.res});
    chk($sformatf("u%0d latency", u), cyc - e.e0, e.lat);
  endtask

  always @(negedge clk) monitor(0);
  always @(negedge clk) monitor(1);

  task automatic issue(input int u, input logic [15:0] x,
                       input logic [15:0] y, input logic s);
    exp_t e;
    @(negedge clk);
    start[u] = 1'b1;
    a[u] = x;
    b[u] = y;
    sm[u] = s;
    @(posedge clk);
    #1;
    e.res = ref_res(x, y, s);
    e.lat = ref_lat(x, y, u == 0 ? 1 : 4, u == 1);
    e.e0 = cyc;
    exp_q[u].push_back(e);
    start[u] = 1'b0;
  endtask

  task automatic wait_idle(input int u);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (exp_q[u].size() == 0 && !busy[u]) return;
    end
    chk($sformatf("u%0d timeout", u), 1, 0);
    exp_q[u].delete();
  endtask

  initial begin
    logic [15:0] x;
    logic [15:0] y;
    bit ok;
    cyc = 0;
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      start[u] = 1'b0;
      sm[u] = 1'b0;
      a[u] = '0;
      b[u] = '0;
    end
    repeat (3) @(negedge clk);
    chk("reset u0 outs",
        {27'd0, busy[0], done[0], lt[0], eq[0], gt[0]}, 0);
    chk("reset u1 outs",
        {27'd0, busy[1], done[1], lt[1], eq[1], gt[1]}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle u0 outs",
        {27'd0, busy[0], done[0], lt[0], eq[0], gt[0]}, 0);

    issue(0, 16'h1234, 16'h1235, 1'b0);
    wait_idle(0);
    issue(0, 16'hFFFF, 16'hFFFF, 1'b0);
    wait_idle(0);
    issue(0, 16'h8000, 16'h0001, 1'b1);
    wait_idle(0);
    issue(0, 16'h8000, 16'h0001, 1'b0);
    wait_idle(0);
    issue(1, 16'hA000, 16'h5000, 1'b0);
    wait_idle(1);
    issue(1, 16'h00F0, 16'h00E0, 1'b0);
    wait_idle(1);
    issue(1, 16'h8000, 16'h0001, 1'b1);
    wait_idle(1);

    // start held while busy, operands wiggling
    issue(0, 16'h1234, 16'h1235, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start[0] = 1'b1;
      a[0] = 16'hFFFF - 16'(i);
      b[0] = 16'(i);
      sm[0] = 1'b1;
    end
    @(negedge clk);
    start[0] = 1'b0;
    wait_idle(0);
    repeat (3) @(negedge clk);
    chk("u0 held start busy", {31'd0, busy[0]}, 0);

    // start in the done cycle
    issue(1, 16'hA000, 16'h5000, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (done[1]) ok = 1'b1;
      else @(negedge clk);
    end
    chk("u1 done seen", {31'd0, ok}, 1);
    start[1] = 1'b1;
    a[1] = 16'h00F0;
    b[1] = 16'h00E0;
    sm[1] = 1'b0;
    @(posedge clk);
    #1;
    exp_q[1].push_back('{3'b001, 3, cyc});
    start[1] = 1'b0;
    chk("u1 back-to-back busy", {31'd0, busy[1]}, 1);
    wait_idle(1);

    // reset in the middle of a long compare
    issue(0, 16'h1234, 16'h1235, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst u0 outs",
        {27'd0, busy[0], done[0], lt[0], eq[0], gt[0]}, 0);
    chk("midrst u1 results",
        {29'd0, lt[1], eq[1], gt[1]}, 0);
    exp_q[0].delete();
    exp_q[1].delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst u0 quiet", {31'd0, busy[0]}, 0);
    issue(0, 16'h7FFF, 16'h8000, 1'b1);
    wait_idle(0);

    // random traffic on both units
    for (int i = 0; i < 40; i++) begin
      for (int u = 0; u < 2; u++) begin
        x = 16'($urandom);
        case ($urandom_range(0, 3))
          0: y = x;
          1: y = x ^ (16'h1 << $urandom_range(0, 15));
          default: y = 16'($urandom);
        endcase
        issue(u, x, y, 1'($urandom));
        wait_idle(u);
      end
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
